// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester push ports, stall and register-file write port of the writeback arbiter
// Ports: stall; v0/a0/d0/rdy0 and v1/a1/d1/rdy1 requester handshakes;
//        wr_en/wr_addr/wr_data register-file write port; busy activity flag.
// master = the requesters and register file side, slave = the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              rdy0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              rdy1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    modport master (
        output stall, v0, a0, d0, v1, a1, d1,
        input  rdy0, rdy1, wr_en, wr_addr, wr_data, busy
    );
    modport slave (
        input  stall, v0, a0, d0, v1, a1, d1,
        output rdy0, rdy1, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between two queued writeback requesters
// Ports: clk, rst_n (async active-low); bus (slave modport) carries stall, the two
//        valid/ready push ports, the registered write port and busy.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] fa [2][DEPTH];
    logic [DATA_W-1:0] fd [2][DEPTH];
    logic [PW-1:0]     wp [2];
    logic [PW-1:0]     rp [2];
    logic [CW-1:0]     cnt [2];
    logic [ADDR_W-1:0] in_a [2];
    logic [DATA_W-1:0] in_d [2];
    logic [1:0]        v, ne, full, cand, push, pop;
    logic              rr_ptr, gnt, any, wr_en;
    logic [ADDR_W-1:0] ha, wr_addr;
    logic [DATA_W-1:0] hd, wr_data;

    assign v       = {bus.v1, bus.v0};
    assign in_a[0] = bus.a0;
    assign in_a[1] = bus.a1;
    assign in_d[0] = bus.d0;
    assign in_d[1] = bus.d1;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ne[i]   = cnt[i] != '0;
            full[i] = cnt[i] == CW'(DEPTH);
        end
        cand = bus.stall ? 2'b00 : ne;
        any  = |cand;
        // lone candidate wins outright; rr_ptr only breaks ties
        gnt  = (cand == 2'b11) ? rr_ptr : cand[1];
        // a full FIFO refuses pushes even when it is being popped this cycle
        push = v & ~full;
        pop  = any ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        ha   = fa[gnt][rp[gnt]];
        hd   = fd[gnt][rp[gnt]];
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (push[i]) begin
                fa[i][wp[i]] <= in_a[i];
                fd[i][wp[i]] <= in_d[i];
            end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            rr_ptr  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i])  rp[i] <= rp[i] + 1'b1;
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (any) begin
                rr_ptr  <= ~gnt;
                wr_addr <= ha;
                wr_data <= hd;
            end
            // writes to register 0 are consumed without asserting the enable
            wr_en <= any && (ha != '0);
        end
    end

    assign bus.rdy0    = rst_n & ~full[0];
    assign bus.rdy1    = rst_n & ~full[1];
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.busy    = (|ne) | wr_en;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed table-driven and sequence checks of regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus();
    regfile_wb_arbiter #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        r0;
        logic        r1;
        logic        busy;
        logic        rr;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.v0 = v0; bus.a0 = a0; bus.d0 = d0;
        bus.v1 = v1; bus.a1 = a1; bus.d1 = d1;
    endtask

    task automatic chk_out(input string t, input logic en, input logic [4:0] addr,
                           input logic [31:0] data, input logic r0, input logic r1,
                           input logic busy);
        chk({t, ".wr_en"}, 32'(bus.wr_en), 32'(en));
        chk({t, ".wr_addr"}, 32'(bus.wr_addr), 32'(addr));
        chk({t, ".wr_data"}, bus.wr_data, data);
        chk({t, ".rdy0"}, 32'(bus.rdy0), 32'(r0));
        chk({t, ".rdy1"}, 32'(bus.rdy1), 32'(r1));
        chk({t, ".busy"}, 32'(bus.busy), 32'(busy));
    endtask

    initial begin
        bus.stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // reset held for three cycles, then released
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("rst%0d", i), 0, 0, 0, 0, 0, 0);
        end
        rst_n = 1'b1;
        #1;
        chk_out("idle", 0, 0, 0, 1, 1, 0);

        // contention, single write, register-zero drop
        tv[0]  = '{1, 2, 15, 1, 3, 45,  0, 0, 0,   1, 1, 1, 0};
        tv[1]  = '{0, 0, 0,  0, 0, 0,   1, 2, 15,  1, 1, 1, 1};
        tv[2]  = '{0, 0, 0,  0, 0, 0,   1, 3, 45,  1, 1, 1, 0};
        tv[3]  = '{0, 0, 0,  0, 0, 0,   0, 3, 45,  1, 1, 0, 0};
        tv[4]  = '{1, 2, 42, 0, 0, 0,   0, 3, 45,  1, 1, 1, 0};
        tv[5]  = '{0, 0, 0,  0, 0, 0,   1, 2, 42,  1, 1, 1, 1};
        tv[6]  = '{0, 0, 0,  0, 0, 0,   0, 2, 42,  1, 1, 0, 1};
        tv[7]  = '{1, 0, 12, 0, 0, 0,   0, 2, 42,  1, 1, 1, 1};
        tv[8]  = '{1, 17, 29, 0, 0, 0,  0, 0, 12,  1, 1, 1, 1};
        tv[9]  = '{0, 0, 0,  0, 0, 0,   1, 17, 29, 1, 1, 1, 1};
        tv[10] = '{0, 0, 0,  0, 0, 0,   0, 17, 29, 1, 1, 0, 1};
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].v0, tv[i].a0, tv[i].d0, tv[i].v1, tv[i].a1, tv[i].d1);
            step();
            chk_out($sformatf("vec%0d", i), tv[i].en, tv[i].addr, tv[i].data,
                    tv[i].r0, tv[i].r1, tv[i].busy);
            chk($sformatf("vec%0d.rr_ptr", i), 32'(dut.rr_ptr), 32'(tv[i].rr));
        end
        drive(0, 0, 0, 0, 0, 0);

        // round-robin with back-pressure under stall
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.stall = 1'b1;
        drive(1, 4, 100, 1, 8, 200);
        step();
        chk_out("rr.push1", 0, 0, 0, 1, 1, 1);
        drive(1, 5, 101, 1, 9, 201);
        step();
        chk_out("rr.push2", 0, 0, 0, 0, 0, 1);
        drive(1, 6, 102, 1, 10, 202);
        step();
        chk_out("rr.blocked", 0, 0, 0, 0, 0, 1);
        bus.stall = 1'b0;
        step();
        chk_out("rr.g0", 1, 4, 100, 1, 0, 1);
        step();
        chk_out("rr.g1", 1, 8, 200, 0, 1, 1);
        bus.v0 = 1'b0;
        step();
        chk_out("rr.g2", 1, 5, 101, 1, 0, 1);
        bus.v1 = 1'b0;
        step();
        chk_out("rr.g3", 1, 9, 201, 1, 1, 1);
        step();
        chk_out("rr.g4", 1, 6, 102, 1, 1, 1);
        step();
        chk_out("rr.g5", 1, 10, 202, 1, 1, 1);
        step();
        chk_out("rr.end", 0, 10, 202, 1, 1, 0);
        chk("rr.rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // reset while entries are queued
        bus.stall = 1'b1;
        drive(1, 7, 300, 1, 11, 400);
        step();
        drive(1, 12, 301, 1, 13, 401);
        step();
        chk_out("mid.full", 0, 10, 202, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        bus.stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out("mid.rst", 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("mid.post%0d", i), 0, 0, 0, 1, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
